// File: rtl/merge_seq_if.sv
// Handshake and memory-side bundle between the merge sequencer and its environment.
interface merge_seq_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          start;
  logic [AW:0]   len1;
  logic [AW:0]   len2;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;
  logic [AW-1:0] cnt1;
  logic [AW-1:0] cnt2;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   out_pos;
  logic          busy;
  logic          done;

  // Sequencer side
  modport slave (
    input  start, len1, len2, r1, r2,
    output cnt1, cnt2, out_valid, out_data, out_pos, busy, done
  );

  // Requester / memory side
  modport master (
    output start, len1, len2, r1, r2,
    input  cnt1, cnt2, out_valid, out_data, out_pos, busy, done
  );
endinterface

// File: rtl/merge_seq.sv
// Merge sequencer: walks two ascending index lists held in a synchronous-read
// memory and emits a single ascending stream, one element every two cycles.
module merge_seq #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  merge_seq_if.slave   bus
);

  localparam logic [AW:0] LMAX = (AW+1)'(1 << AW);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx1_q, idx1_d, idx2_q, idx2_d;
  logic [AW:0]   emit_q, emit_d;
  logic [AW:0]   l1_q, l1_d, l2_q, l2_d;
  logic [AW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW:0]   pos_q, pos_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          rem1, rem2, take1;
  logic [AW:0]   idx1_inc, idx2_inc;

  // Lengths beyond the list depth are treated as a full list.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    if (len > LMAX) return LMAX;
    return len;
  endfunction

  // A list still has entries while its index is below its latched length;
  // ties go to list 1 so equal keys keep their list order.
  assign rem1     = (idx1_q < l1_q);
  assign rem2     = (idx2_q < l2_q);
  assign take1    = rem1 && (!rem2 || (bus.r1 <= bus.r2));
  assign idx1_inc = idx1_q + 1'b1;
  assign idx2_inc = idx2_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   state_d = EMIT;
      EMIT:    state_d = (rem1 || rem2) ? FETCH : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and merge bookkeeping
  always_comb begin
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    emit_d = emit_q;
    l1_d   = l1_q;
    l2_d   = l2_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    vld_d  = 1'b0;
    data_d = data_q;
    pos_d  = pos_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          l1_d   = clamp_len(bus.len1);
          l2_d   = clamp_len(bus.len2);
          idx1_d = '0;
          idx2_d = '0;
          emit_d = '0;
          cnt1_d = '0;
          cnt2_d = '0;
          busy_d = 1'b1;
        end
      end
      EMIT: begin
        if (take1) begin
          vld_d  = 1'b1;
          data_d = bus.r1;
          pos_d  = emit_q;
          emit_d = emit_q + 1'b1;
          idx1_d = idx1_inc;
          cnt1_d = idx1_inc[AW-1:0];
        end else if (rem2) begin
          vld_d  = 1'b1;
          data_d = bus.r2;
          pos_d  = emit_q;
          emit_d = emit_q + 1'b1;
          idx2_d = idx2_inc;
          cnt2_d = idx2_inc[AW-1:0];
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx1_q <= '0;
      idx2_q <= '0;
      emit_q <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      pos_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      emit_q <= emit_d;
      l1_q   <= l1_d;
      l2_q   <= l2_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      pos_q  <= pos_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.cnt1      = cnt1_q;
  assign bus.cnt2      = cnt2_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_pos   = pos_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_merge_seq.sv
// Bench for merge_seq: a synchronous-read memory model feeds the sequencer,
// a reference merge fills a scoreboard, and each scenario task checks the stream.
module tb_merge_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  merge_seq_if #(.DW(8), .AW(4)) bus ();

  merge_seq #(.DW(8), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] m1 [16];
  logic [7:0] m2 [16];

  // Index memory: data valid one cycle after the address
  always @(posedge clk) begin
    bus.r1 <= m1[bus.cnt1];
    bus.r2 <= m2[bus.cnt2];
  end

  typedef struct {
    logic [7:0] data;
    logic [4:0] pos;
    int         cyc;
    logic [3:0] c1;
    logic [3:0] c2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic load_lists(input int base1, input int step1, input int base2, input int step2);
    for (int i = 0; i < 16; i++) begin
      m1[i] = 8'(base1 + i * step1);
      m2[i] = 8'(base2 + i * step2);
    end
  endtask

  // Reference merge: pushes every expected element with its cycle and addresses.
  task automatic build_expected(input int la, input int lb, output int done_cyc);
    int i, j, k, a, b;
    exp_t e;
    a = (la > 16) ? 16 : la;
    b = (lb > 16) ? 16 : lb;
    i = 0; j = 0; k = 0;
    while (i < a || j < b) begin
      if (i < a && (j >= b || m1[i] <= m2[j])) begin
        e.data = m1[i];
        i++;
      end else begin
        e.data = m2[j];
        j++;
      end
      e.pos = 5'(k);
      e.cyc = 2 * k + 3;
      e.c1  = 4'(i);
      e.c2  = 4'(j);
      sb.push_back(e);
      k++;
    end
    done_cyc = 2 * (a + b) + 3;
  endtask

  // Starts a merge and follows it to completion against the scoreboard.
  task automatic run_merge(input string name, input int la, input int lb, input int restart_cycle);
    int dc;
    bit seen;
    exp_t e;
    build_expected(la, lb, dc);
    @(negedge clk);
    bus.len1  = 5'(la);
    bus.len2  = 5'(lb);
    bus.start = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= dc + 4 && !seen; c++) begin
      @(negedge clk);
      bus.start = (c == restart_cycle);
      bus.len1  = 5'(c * 7);
      bus.len2  = 5'(c * 3);
      if (c == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_c1 got=%b exp=1", name, bus.busy);
        end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL %s extra_out cycle=%0d data=%0d", name, c, bus.out_data);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_pos !== e.pos || c != e.cyc ||
              bus.cnt1 !== e.c1 || bus.cnt2 !== e.c2) begin
            failures++;
            $display("FAIL %s elem got data=%0d pos=%0d cyc=%0d cnt1=%0d cnt2=%0d exp data=%0d pos=%0d cyc=%0d cnt1=%0d cnt2=%0d",
                     name, bus.out_data, bus.out_pos, c, bus.cnt1, bus.cnt2,
                     e.data, e.pos, e.cyc, e.c1, e.c2);
          end
        end
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (c != dc || bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL %s done got cyc=%0d busy=%b exp cyc=%0d busy=0", name, c, bus.busy, dc);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s done_timeout got=none exp cyc=%0d", name, dc);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_outputs got_left=%0d exp=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.len1 = '0;
    bus.len2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_pos !== 5'd0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt1 !== 4'd0 || bus.cnt2 !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle got vld=%b data=%0d pos=%0d busy=%b done=%b cnt1=%0d cnt2=%0d exp all 0",
                 bus.out_valid, bus.out_data, bus.out_pos, bus.busy, bus.done, bus.cnt1, bus.cnt2);
      end
    end
  endtask

  task automatic test_basic();
    m1[0] = 8'd1; m1[1] = 8'd4; m1[2] = 8'd9;
    m2[0] = 8'd2; m2[1] = 8'd3; m2[2] = 8'd10;
    run_merge("basic", 3, 3, 0);
  endtask

  task automatic test_tie();
    m1[0] = 8'd5; m1[1] = 8'd5; m1[2] = 8'd0;
    m2[0] = 8'd5; m2[1] = 8'd0;
    run_merge("tie", 2, 1, 0);
  endtask

  task automatic test_lengths();
    load_lists(0, 1, 200, 1);
    run_merge("full_l1", 16, 0, 0);
    run_merge("empty", 0, 0, 0);
    load_lists(100, 3, 50, 11);
    run_merge("full_both", 16, 16, 0);
  endtask

  task automatic test_clamp();
    load_lists(0, 1, 7, 0);
    run_merge("clamp", 20, 1, 0);
  endtask

  task automatic test_restart();
    load_lists(0, 1, 0, 1);
    m1[0] = 8'd1; m1[1] = 8'd4; m1[2] = 8'd9;
    m2[0] = 8'd2; m2[1] = 8'd3; m2[2] = 8'd10;
    run_merge("restart_ignored", 3, 3, 4);
  endtask

  task automatic test_reset_abort();
    int dc;
    exp_t e;
    m1[0] = 8'd1; m1[1] = 8'd4; m1[2] = 8'd9;
    m2[0] = 8'd2; m2[1] = 8'd3; m2[2] = 8'd10;
    build_expected(3, 3, dc);
    @(negedge clk);
    bus.len1 = 5'd3;
    bus.len2 = 5'd3;
    bus.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_pos !== e.pos || c != e.cyc) begin
          failures++;
          $display("FAIL abort_pre elem got data=%0d pos=%0d cyc=%0d exp data=%0d pos=%0d cyc=%0d",
                   bus.out_data, bus.out_pos, c, e.data, e.pos, e.cyc);
        end
      end
      if (c == 6) reset = 1'b1;
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_pos !== 5'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt1 !== 4'd0 || bus.cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL abort_reset got vld=%b data=%0d pos=%0d busy=%b done=%b cnt1=%0d cnt2=%0d exp all 0",
               bus.out_valid, bus.out_data, bus.out_pos, bus.busy, bus.done, bus.cnt1, bus.cnt2);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet got done=%b vld=%b busy=%b exp 0 0 0", bus.done, bus.out_valid, bus.busy);
      end
    end
    load_lists(3, 2, 4, 2);
    run_merge("after_abort", 4, 5, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len1 = '0;
    bus.len2 = '0;
    reset = 1'b1;
    load_lists(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_tie();
    test_lengths();
    test_clamp();
    test_restart();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merge_seq.md
Name: merge_seq

Overview:
- Sequencer that drives the two index-list read addresses (cnt1, cnt2) of the dual index memory.
- Consumes the read data r1/r2 and emits one merged, ascending-ordered stream of 8-bit indices.
- Sits directly downstream of the index memory. It replaces ad-hoc compare/advance logic with a defined FSM, length handling and a completion handshake.
- Both lists are sorted ascending by the upstream writer; this block does not check that.

Parameters:
- DW, 8, data width of each list entry.
- AW, 4, list address width; depth per list = 2^AW = 16.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a merge; sampled only in IDLE.
- len1  in  AW+1  number of valid entries in list 1 (0..16); sampled on the start edge.
- len2  in  AW+1  number of valid entries in list 2 (0..16); sampled on the start edge.
- r1  in  DW  list-1 read data; synchronous read, valid one cycle after cnt1 is presented.
- r2  in  DW  list-2 read data; same timing as r1.
- cnt1  out  AW  list-1 read address.
- cnt2  out  AW  list-2 read address.
- out_valid  out  1  one-cycle pulse: out_data/out_pos hold a merged element.
- out_data  out  DW  merged element.
- out_pos  out  AW+1  position of the element in the merged stream (0..31).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; cnt1=cnt2=0; out_valid=0; out_data=0; out_pos=0; busy=0; done=0.
  - Reset during a merge aborts it immediately.
  - No done pulse is produced for the aborted merge; state returns to IDLE.
- Internal state:
  - Indices idx1 and idx2, each AW+1 bits.
  - Emit counter, AW+1 bits.
  - Latched lengths L1 and L2. A length value above 16 is clamped to 16 when latched.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 -> latch L1/L2, clear idx1/idx2/emit counter, cnt1=cnt2=0, busy=1 -> FETCH. Otherwise hold.
  - FETCH: wait state covering the one-cycle read latency -> EMIT.
  - EMIT: compute rem1 = (idx1 < L1) and rem2 = (idx2 < L2).
    - rem1 and rem2, r1 <= r2: emit r1, increment idx1.
    - rem1 and rem2, r1 > r2: emit r2, increment idx2.
    - Ties select list 1 (stable merge).
    - Only rem1: emit r1, increment idx1. Only rem2: emit r2, increment idx2.
    - After any emit: -> FETCH.
    - Neither remaining: no emit -> DONE.
  - DONE: done=1 and busy=0 for this cycle -> IDLE.
- Emit mechanics:
  - On the edge leaving EMIT, out_valid=1, out_data=selected value, out_pos=emit counter; then the emit counter increments.
  - cnt1/cnt2 take the low AW bits of the new idx1/idx2 on the same edge.
  - out_valid clears on the following edge.
- Wrap-around: when idx reaches 16, cnt wraps to 0. The stale r data read there is ignored because the matching rem flag is 0.
- Timing: cycle 1 is the cycle after the start edge.
  - Merged element k (0-based) is visible in cycle 2k+3.
  - done is high in cycle 2N+3, where N = L1+L2.
  - N=0 gives done in cycle 3 with no out_valid.
  - Throughput is one element per 2 cycles.
- start while busy, or in DONE: ignored; no restart and no error.
- len inputs may change freely after the start edge.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, cnt1=cnt2=0, no done.
- list1={1,4,9}, list2={2,3,10}, L1=L2=3, start -> out_data sequence 1,2,3,4,9,10 with out_pos 0..5 in cycles 3,5,7,9,11,13; done in cycle 15.
- Tie test: list1={5,5}, list2={5}, L1=2, L2=1 -> three outputs of 5, sourced list1, list1, list2 (check the cnt1/cnt2 advance order); done in cycle 9.
- Lengths L1=16 (0..15) and L2=0 -> 16 outputs 0..15; cnt1 wraps to 0 after the last emit; done in cycle 35. Also L1=L2=0 -> no out_valid, done in cycle 3.
- Assert start again in cycle 4 of a running merge -> ignored, output stream unchanged. Then assert reset in cycle 6 -> outputs return to reset values next cycle, no done pulse; a new start merges correctly.
- L1=20 (clamp), L2=1 -> exactly 17 outputs, done in cycle 37.
